hysteresis_track: RTL and testbench

Hysteresis edge-tracking stage of the Canny pipeline. Consumes the per-pixel class stream produced by the double-threshold stage and emits the final binary edge map:
- Class 0 = none, 1 = weak, 2 = strong.
- A strong pixel is an edge.
- A weak pixel is an edge only if one of its 8 neighbours is strong.

It is a single-pass 3x3 window built on two line buffers. An internal flush drains the last image row after the final input pixel.

---
 rtl/hysteresis_track.sv | 151 +++++++++++++++
 tb/tb_hysteresis_track.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hysteresis_track.sv
// rtl/hysteresis_track.sv - Canny hysteresis stage: 3x3 weak/strong edge tracking over two line buffers
module hysteresis_track #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_sof,
    input  logic [7:0] in_pix,
    output logic       out_valid,
    output logic [7:0] out_pix,
    output logic       out_eof
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int FW = $clog2(IMG_WIDTH + 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

    typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
    state_t state, state_nx;

    logic            ready_q;
    logic [1:0]      lb_a [IMG_WIDTH];
    logic [1:0]      lb_b [IMG_WIDTH];
    logic [2:0][1:0] win_top, win_mid, win_bot;
    logic [2:0][1:0] nx_top, nx_mid, nx_bot;
    logic [CW-1:0]   icol, ocol, col_sel;
    logic [RW-1:0]   irow, orow;
    logic [FW-1:0]   fcnt;

    logic       xfer, sof_xfer, step, emit, last_in, fill_done, edge_hit;
    logic       has_up, has_dn, has_l, has_r;
    logic [1:0] in_cls, new_top, new_mid, new_bot;
    logic [7:0] strong_map;
    logic       unused_hi;

    assign unused_hi = ^in_pix[7:2];
    assign in_ready  = ready_q && (state != FLUSH);
    assign xfer      = in_valid && in_ready;
    assign sof_xfer  = xfer && in_sof;
    assign in_cls    = (in_pix[1:0] == 2'd3) ? 2'd0 : in_pix[1:0];
    assign step      = sof_xfer || (xfer && state != IDLE) || (state == FLUSH);
    assign emit      = (state == RUN && xfer && !in_sof) || (state == FLUSH);
    assign last_in   = (irow == ROW_LAST) && (icol == COL_LAST);
    assign fill_done = (irow == RW'(1)) && (icol == '0);

    // A start-of-frame pixel always lands in column 0, whatever the counter held.
    assign col_sel = sof_xfer ? '0 : icol;
    assign new_top = lb_b[col_sel];
    assign new_mid = lb_a[col_sel];
    assign new_bot = (state == FLUSH) ? 2'd0 : in_cls;

    assign nx_top = sof_xfer ? {4'b0, new_top} : {win_top[1], win_top[0], new_top};
    assign nx_mid = sof_xfer ? {4'b0, new_mid} : {win_mid[1], win_mid[0], new_mid};
    assign nx_bot = sof_xfer ? {4'b0, new_bot} : {win_bot[1], win_bot[0], new_bot};

    // Index 0 is the right-hand column, 2 the left; stale or out-of-image taps are masked here.
    assign has_up = (orow != '0);
    assign has_dn = (orow != ROW_LAST);
    assign has_l  = (ocol != '0);
    assign has_r  = (ocol != COL_LAST);

    assign strong_map = {
        has_up && has_l && (nx_top[2] == 2'd2),
        has_up &&          (nx_top[1] == 2'd2),
        has_up && has_r && (nx_top[0] == 2'd2),
                  has_l && (nx_mid[2] == 2'd2),
                  has_r && (nx_mid[0] == 2'd2),
        has_dn && has_l && (nx_bot[2] == 2'd2),
        has_dn &&          (nx_bot[1] == 2'd2),
        has_dn && has_r && (nx_bot[0] == 2'd2)
    };
    assign edge_hit = (nx_mid[1] == 2'd2) || ((nx_mid[1] == 2'd1) && (|strong_map));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (sof_xfer) state_nx = FILL;
            FILL:    if (sof_xfer) state_nx = FILL;
                     else if (xfer && fill_done) state_nx = RUN;
            RUN:     if (sof_xfer) state_nx = FILL;
                     else if (xfer && last_in) state_nx = FLUSH;
            FLUSH:   if (fcnt == FLUSH_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_q   <= 1'b0;
            icol      <= '0;
            irow      <= '0;
            ocol      <= '0;
            orow      <= '0;
            fcnt      <= '0;
            win_top   <= '0;
            win_mid   <= '0;
            win_bot   <= '0;
            out_valid <= 1'b0;
            out_pix   <= 8'h00;
            out_eof   <= 1'b0;
        end else begin
            state     <= state_nx;
            ready_q   <= 1'b1;
            out_valid <= emit;
            out_eof   <= emit && (orow == ROW_LAST) && (ocol == COL_LAST);
            if (emit) out_pix <= edge_hit ? 8'hFF : 8'h00;
            fcnt <= (state == FLUSH) ? fcnt + 1'b1 : '0;

            if (step) begin
                win_top <= nx_top;
                win_mid <= nx_mid;
                win_bot <= nx_bot;
                if (sof_xfer) begin
                    icol <= CW'(1);
                    irow <= '0;
                end else if (icol == COL_LAST) begin
                    icol <= '0;
                    irow <= irow + 1'b1;
                end else begin
                    icol <= icol + 1'b1;
                end
            end

            if (sof_xfer) begin
                ocol <= '0;
                orow <= '0;
            end else if (emit) begin
                if (ocol == COL_LAST) begin
                    ocol <= '0;
                    orow <= (orow == ROW_LAST) ? '0 : orow + 1'b1;
                end else begin
                    ocol <= ocol + 1'b1;
                end
            end
        end
    end

    // Line buffers carry no reset: rows they hold from an earlier frame are masked above.
    always_ff @(posedge clk) begin
        if (step) begin
            lb_a[col_sel] <= new_bot;
            lb_b[col_sel] <= new_mid;
        end
    end
endmodule

// File: tb/tb_hysteresis_track.sv
// tb/tb_hysteresis_track.sv - self-checking bench for hysteresis_track on a 4x3 frame
module tb_hysteresis_track;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_pix = 8'h00;
    logic       in_ready, out_valid, out_eof;
    logic [7:0] out_pix;

    always #5 clk = ~clk;

    hysteresis_track #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sof(in_sof), .in_pix(in_pix), .out_valid(out_valid),
        .out_pix(out_pix), .out_eof(out_eof)
    );

    int n_checks = 0;
    int n_fail = 0;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    logic [1:0] img [N];
    logic [5:0] hi [N];

    function automatic int cl(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 0;
        return (img[r*W+c] == 2'd3) ? 0 : int'(img[r*W+c]);
    endfunction

    // Edge rule straight from the class definitions, evaluated on the full stored frame.
    function automatic int model(input int k);
        int r, c, p;
        r = k / W;
        c = k % W;
        p = cl(r, c);
        if (p == 2) return 'hFF;
        if (p == 1)
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if ((dr != 0 || dc != 0) && cl(r + dr, c + dc) == 2) return 'hFF;
        return 0;
    endfunction

    int cyc = 0, gen = 0, pidx = 0, last_cyc = 0, last_idx = -1;
    bit active = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) active = 1'b0;
        else if (in_valid && in_ready) begin
            if (in_sof) begin
                gen++; pidx = 0; active = 1'b1; last_cyc = cyc; last_idx = 0;
            end else if (active) begin
                pidx++; last_cyc = cyc; last_idx = pidx;
                if (pidx == N - 1) active = 1'b0;
            end
        end
    end

    int outs = 0, eofs = 0, seen_gen = 0, vcount = 0;
    bit armed = 1'b0;
    logic [7:0] last_pix = 8'h00;
    logic [7:0] got [N];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            armed = 1'b0; outs = 0; eofs = 0; last_pix = 8'h00; seen_gen = gen;
        end else begin
            if (gen != seen_gen) begin
                seen_gen = gen; armed = 1'b1; outs = 0; eofs = 0;
            end
            if (out_valid) begin
                vcount++;
                if (!armed || outs >= N) check("spurious_out_valid", int'(out_valid), 0);
                else begin
                    check("out_pix", int'(out_pix), model(outs));
                    check("out_eof", int'(out_eof), int'(outs == N - 1));
                    if (outs + W + 1 <= N - 1)
                        check("latency", int'(last_idx == outs + W + 1 && cyc == last_cyc), 1);
                    else
                        check("flush_timing",
                              int'(last_idx == N - 1 && cyc == last_cyc + outs - (N - W - 2)), 1);
                    got[outs] = out_pix;
                    outs++;
                    if (out_eof) eofs++;
                end
                last_pix = out_pix;
            end else begin
                check("eof_idle", int'(out_eof), 0);
                check("pix_hold", int'(out_pix), int'(last_pix));
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] pix, input bit sof);
        int t;
        t = 0;
        in_valid = 1'b1; in_pix = pix; in_sof = sof;
        @(negedge clk);
        while (!in_ready && t < 50) begin t++; @(negedge clk); end
        if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic run_frame(input int npix, input bit gaps, input bit measure);
        int lows;
        for (int i = 0; i < npix; i++) begin
            if (gaps && $urandom_range(1) != 0) idle(1);
            send({hi[i], img[i]}, i == 0);
        end
        if (measure) begin
            lows = 0;
            @(negedge clk);
            while (!in_ready && lows < 20) begin lows++; @(negedge clk); end
            check("in_ready_low_cycles", lows, W + 1);
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int got_mask();
        logic [N-1:0] m;
        for (int i = 0; i < N; i++) m[i] = (got[i] == 8'hFF);
        return int'(m);
    endfunction

    task automatic full_frame(input bit gaps, input bit use_mask, input int exp_mask);
        for (int i = 0; i < N; i++) got[i] = 8'h5A;
        run_frame(N, gaps, 1'b1);
        idle(3);
        check("frame_outputs", outs, N);
        check("frame_eofs", eofs, 1);
        if (use_mask) check("edge_mask", got_mask(), exp_mask);
    endtask

    task automatic clear_img();
        for (int i = 0; i < N; i++) begin img[i] = 2'd0; hi[i] = 6'd0; end
    endtask

    task automatic rand_img();
        for (int i = 0; i < N; i++) begin img[i] = 2'($urandom_range(3)); hi[i] = 6'($urandom); end
    endtask

    initial begin
        int v0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_pix", int'(out_pix), 0);
        check("rst_out_eof", int'(out_eof), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        check("ready_after_rst", int'(in_ready), 1);
        @(posedge clk); #1;

        clear_img();
        full_frame(1'b0, 1'b1, 'h000);

        clear_img();
        img[1*W+1] = 2'd2; img[1*W+2] = 2'd1; img[2*W+3] = 2'd1;
        full_frame(1'b0, 1'b1, 'h060);

        clear_img();
        img[0*W+3] = 2'd2; img[1*W+0] = 2'd1;
        full_frame(1'b1, 1'b1, 'h008);

        clear_img();
        img[0] = 2'd1; img[1*W+1] = 2'd2;
        full_frame(1'b1, 1'b1, 'h021);

        for (int i = 0; i < N; i++) begin img[i] = 2'd3; hi[i] = 6'($urandom); end
        img[1*W+2] = 2'd2; img[0] = 2'd1;
        full_frame(1'b0, 1'b1, 'h040);

        // Non-sof pixels while idle must be ignored, then a frame aborted after 7 pixels.
        send(8'h02, 1'b0);
        send(8'h06, 1'b0);
        idle(3);
        rand_img();
        run_frame(7, 1'b1, 1'b0);
        idle(3);
        check("abort_outputs", outs, 7 - W - 1);
        check("abort_eofs", eofs, 0);
        rand_img();
        full_frame(1'b1, 1'b0, 0);

        for (int f = 0; f < 15; f++) begin
            rand_img();
            full_frame(1'b1, 1'b0, 0);
        end

        rand_img();
        run_frame(N, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midflush_rst_valid", int'(out_valid), 0);
        check("midflush_rst_eof", int'(out_eof), 0);
        check("midflush_rst_pix", int'(out_pix), 0);
        check("midflush_rst_ready", int'(in_ready), 0);
        v0 = vcount;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(12);
        check("no_out_after_rst", vcount - v0, 0);
        rand_img();
        full_frame(1'b1, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
